// File: rtl/char_position_ctrl.sv
// Character-box position controller: synchronised direction buttons drive
// single steps plus delayed auto-repeat, moving a box inside the display area.
module char_position_ctrl #(
  parameter int HDT        = 640,
  parameter int VDT        = 400,
  parameter int HAL        = 8,
  parameter int VAL        = 16,
  parameter int CHM        = 1,
  parameter int PW         = 10,
  parameter int DLY_CYCLES = 12500000,
  parameter int RPT_CYCLES = 2500000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    offsetFlag,
  output logic [PW-1:0] posVerStart,
  output logic [PW-1:0] posVerEnd,
  output logic [PW-1:0] posHorStart,
  output logic [PW-1:0] posHorEnd,
  output logic          moved
);

  localparam int HSTEP = HAL * CHM;
  localparam int VSTEP = VAL * CHM;
  localparam int CMAX  = (DLY_CYCLES > RPT_CYCLES) ? DLY_CYCLES : RPT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [PW-1:0] HSTEP_P = PW'(HSTEP);
  localparam logic [PW-1:0] VSTEP_P = PW'(VSTEP);
  localparam logic [PW-1:0] HOME_HS = PW'((HDT - HSTEP) / 2);
  localparam logic [PW-1:0] HOME_VS = PW'((VDT - VSTEP) / 2);
  localparam logic [PW:0]   HSTEP_W = (PW+1)'(HSTEP);
  localparam logic [PW:0]   VSTEP_W = (PW+1)'(VSTEP);
  localparam logic [PW:0]   HDT_W   = (PW+1)'(HDT);
  localparam logic [PW:0]   VDT_W   = (PW+1)'(VDT);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [3:0]    sync1;
  logic [3:0]    dir;
  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [3:0]    last_dir, last_dir_nxt;
  logic          step;
  logic          expired;

  // Two-flop synchroniser; the buttons are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      dir   <= '0;
    end else begin
      // NOTE: non-blocking so dir takes last cycle's sync1, giving two real flops.
      sync1 <= offsetFlag;
      dir   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      last_dir <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      last_dir <= last_dir_nxt;
    end
  end

  // A count of 1 means the current edge is the last one of the wait interval.
  assign expired = (count == '0) || (count == CW'(1));

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt    = state;
    count_nxt    = count;
    last_dir_nxt = last_dir;
    step         = 1'b0;
    case (state)
      IDLE: begin
        if (dir != 4'b0000) begin
          step         = 1'b1;
          count_nxt    = CW'(DLY_CYCLES);
          last_dir_nxt = dir;
          state_nxt    = HOLD;
        end
      end
      default: begin
        if (dir == 4'b0000) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end else if (dir != last_dir) begin
          step         = 1'b1;
          count_nxt    = CW'(DLY_CYCLES);
          last_dir_nxt = dir;
          state_nxt    = HOLD;
        end else if (expired) begin
          step      = 1'b1;
          count_nxt = CW'(RPT_CYCLES);
          state_nxt = REPEAT;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
    endcase
  end

  // Bounds are compared one bit wider than the outputs so End+step cannot wrap.
  logic [PW:0]   hs_w, he_w, vs_w, ve_w;
  logic          left_ok, right_ok, up_ok, down_ok;
  logic [PW-1:0] hs_nxt, vs_nxt;

  assign hs_w = {1'b0, posHorStart};
  assign he_w = {1'b0, posHorEnd};
  assign vs_w = {1'b0, posVerStart};
  assign ve_w = {1'b0, posVerEnd};

  assign left_ok  = step && dir[1] && !dir[0] && (hs_w >= HSTEP_W);
  assign right_ok = step && dir[0] && !dir[1] && ((he_w + HSTEP_W) <= HDT_W);
  assign up_ok    = step && dir[3] && !dir[2] && (vs_w >= VSTEP_W);
  assign down_ok  = step && dir[2] && !dir[3] && ((ve_w + VSTEP_W) <= VDT_W);

  always_comb begin
    hs_nxt = posHorStart;
    vs_nxt = posVerStart;
    if (left_ok)  hs_nxt = posHorStart - HSTEP_P;
    if (right_ok) hs_nxt = posHorStart + HSTEP_P;
    if (up_ok)    vs_nxt = posVerStart - VSTEP_P;
    if (down_ok)  vs_nxt = posVerStart + VSTEP_P;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      posHorStart <= HOME_HS;
      posHorEnd   <= HOME_HS + HSTEP_P;
      posVerStart <= HOME_VS;
      posVerEnd   <= HOME_VS + VSTEP_P;
      moved       <= 1'b0;
    end else begin
      posHorStart <= hs_nxt;
      posHorEnd   <= hs_nxt + HSTEP_P;
      posVerStart <= vs_nxt;
      posVerEnd   <= vs_nxt + VSTEP_P;
      moved       <= left_ok || right_ok || up_ok || down_ok;
    end
  end

endmodule

// File: tb/tb_char_position_ctrl.sv
// Bench for char_position_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a time-based behavioural model.
module tb_char_position_ctrl;

  localparam int HDT = 640;
  localparam int VDT = 400;
  localparam int HS  = 8;
  localparam int VS  = 16;
  localparam int DLY = 4;
  localparam int RPT = 2;
  localparam int PW  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    offsetFlag;
  logic [PW-1:0] posVerStart, posVerEnd, posHorStart, posHorEnd;
  logic          moved;

  char_position_ctrl #(
    .HDT(HDT), .VDT(VDT), .HAL(8), .VAL(16), .CHM(1), .PW(PW),
    .DLY_CYCLES(DLY), .RPT_CYCLES(RPT)
  ) dut (
    .clk(clk), .reset(reset), .offsetFlag(offsetFlag),
    .posVerStart(posVerStart), .posVerEnd(posVerEnd),
    .posHorStart(posHorStart), .posHorEnd(posHorEnd),
    .moved(moved)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int moved_seen = 0;

  // Reference model: button history, hold timing by absolute cycle numbers.
  int       m_hs, m_vs, now, due;
  bit       m_moved, active;
  bit [3:0] h1, h2, act_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hs = (HDT - HS) / 2;
    m_vs = (VDT - VS) / 2;
    m_moved = 1'b0;
    active = 1'b0;
    h1 = '0;
    h2 = '0;
    act_dir = '0;
  endtask

  // Flag applied before edge k is acted on at edge k+2.
  task automatic model_edge(input bit [3:0] f);
    bit [3:0] d;
    bit       stp;
    int       ohs, ovs;
    now++;
    d = h2;
    h2 = h1;
    h1 = f;
    stp = 1'b0;
    if (d == 4'd0) active = 1'b0;
    else if (!active || d != act_dir) begin
      stp = 1'b1; active = 1'b1; act_dir = d; due = now + DLY;
    end else if (now == due) begin
      stp = 1'b1; due = now + RPT;
    end
    ohs = m_hs;
    ovs = m_vs;
    if (stp) begin
      if (d[1] && !d[0] && m_hs - HS >= 0)         m_hs = m_hs - HS;
      if (d[0] && !d[1] && m_hs + 2 * HS <= HDT)   m_hs = m_hs + HS;
      if (d[3] && !d[2] && m_vs - VS >= 0)         m_vs = m_vs - VS;
      if (d[2] && !d[3] && m_vs + 2 * VS <= VDT)   m_vs = m_vs + VS;
    end
    m_moved = (ohs != m_hs) || (ovs != m_vs);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_hs"}, posHorStart, m_hs);
    check({tag, "_he"}, posHorEnd, m_hs + HS);
    check({tag, "_vs"}, posVerStart, m_vs);
    check({tag, "_ve"}, posVerEnd, m_vs + VS);
    check({tag, "_mv"}, moved, m_moved);
  endtask

  // Called at a negedge; drives f, runs one edge, compares at the next negedge.
  task automatic tick(input string tag, input bit [3:0] f);
    offsetFlag = f;
    @(posedge clk);
    model_edge(f);
    @(negedge clk);
    compare_all(tag);
    if (moved) moved_seen++;
  endtask

  task automatic ticks(input string tag, input bit [3:0] f, input int n);
    for (int i = 0; i < n; i++) tick(tag, f);
  endtask

  // Asynchronous reset between edges, held across two edges, released low-phase.
  task automatic do_reset(input bit [3:0] f);
    #2;
    reset = 1'b1;
    offsetFlag = f;
    #1;
    model_reset();
    compare_all("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("rst_held");
    reset = 1'b0;
    moved_seen = 0;
  endtask

  initial begin
    reset = 1'b0;
    offsetFlag = 4'd0;
    now = 0;
    due = 0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("home_hs", posHorStart, 316);
    check("home_he", posHorEnd, 324);
    check("home_vs", posVerStart, 192);
    check("home_ve", posVerEnd, 208);
    check("home_mv", moved, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single right pulse
    ticks("idle", 4'b0000, 2);
    tick("rpulse", 4'b0001);
    ticks("rpulse_rel", 4'b0000, 8);
    check("rpulse_hs", posHorStart, 324);
    check("rpulse_he", posHorEnd, 332);
    check("rpulse_cnt", moved_seen, 1);

    // left held to the edge
    do_reset(4'b0000);
    ticks("left_hold", 4'b0010, 100);
    check("left_stop_hs", posHorStart, 4);
    check("left_stop_he", posHorEnd, 12);
    moved_seen = 0;
    ticks("left_blocked", 4'b0010, 10);
    check("left_blocked_cnt", moved_seen, 0);
    ticks("left_rel", 4'b0000, 3);

    // right held to the edge
    do_reset(4'b0000);
    ticks("right_hold", 4'b0001, 100);
    check("right_stop_hs", posHorStart, 628);
    check("right_stop_he", posHorEnd, 636);
    ticks("right_rel", 4'b0000, 3);

    // up+down cancels, up+right is diagonal
    do_reset(4'b0000);
    ticks("updown", 4'b1100, 10);
    check("updown_vs", posVerStart, 192);
    check("updown_cnt", moved_seen, 0);
    ticks("updown_rel", 4'b0000, 3);
    tick("diag", 4'b1001);
    ticks("diag_rel", 4'b0000, 6);
    check("diag_vs", posVerStart, 176);
    check("diag_hs", posHorStart, 324);

    // direction change mid-repeat
    do_reset(4'b0000);
    ticks("chg_left", 4'b0010, 12);
    ticks("chg_down", 4'b0100, 12);
    ticks("chg_rel", 4'b0000, 3);

    // reset mid-repeat, then button held through reset release
    ticks("mid_left", 4'b0010, 11);
    do_reset(4'b0000);
    ticks("post_rst", 4'b0000, 5);
    check("post_rst_cnt", moved_seen, 0);
    do_reset(4'b1000);
    ticks("held_rst", 4'b1000, 12);
    ticks("held_rel", 4'b0000, 3);

    // random traffic
    for (int s = 0; s < 250; s++) begin
      bit [3:0] f;
      int len;
      f = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) do_reset(f);
      ticks("rand", f, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_position_ctrl.md
CHAR_POSITION_CTRL -- requirements
Module: char_position_ctrl

Interface
REQ-001 SHALL have parameter HDT, default 640, meaning horizontal display time in pixels.
REQ-002 SHALL have parameter VDT, default 400, meaning vertical display time in lines.
REQ-003 SHALL have parameter HAL, default 8, meaning character width in pixels before magnification.
REQ-004 SHALL have parameter VAL, default 16, meaning character height in lines before magnification.
REQ-005 SHALL have parameter CHM, default 1, meaning integer character magnify factor (>=1).
REQ-006 SHALL have parameter PW, default 10, meaning position output width; PW holds max(HDT,VDT).
REQ-007 SHALL have parameter DLY_CYCLES, default 12500000, meaning hold time before auto-repeat starts.
REQ-008 SHALL have parameter RPT_CYCLES, default 2500000, meaning auto-repeat period.
REQ-009 SHALL have port clk  input  1  the single clock; one clock, all state on its rising edge.
REQ-010 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-011 SHALL have port offsetFlag  input  4  asynchronous move requests {up,down,left,right}; bit3=up, bit0=right.
REQ-012 SHALL have port posVerStart  output  PW  first active line of the character box.
REQ-013 SHALL have port posVerEnd  output  PW  posVerStart + VAL*CHM.
REQ-014 SHALL have port posHorStart  output  PW  first active pixel of the character box.
REQ-015 SHALL have port posHorEnd  output  PW  posHorStart + HAL*CHM.
REQ-016 SHALL have port moved  output  1  one-cycle pulse when any position register changes.

Function
REQ-017 SHALL pass offsetFlag through a 2-flop synchroniser per bit; the synchronised vector is "dir".
REQ-018 SHALL run FSM IDLE/HOLD/REPEAT with a down-counter wide enough for max(DLY_CYCLES,RPT_CYCLES).
REQ-019 SHALL, in IDLE with dir!=0, raise a step event, load counter with DLY_CYCLES, go to HOLD.
REQ-020 SHALL, in HOLD or REPEAT with dir==0, go to IDLE without a step event.
REQ-021 SHALL, in HOLD or REPEAT with dir changed to a different nonzero value, raise a step event with the new dir, reload DLY_CYCLES, go to HOLD.
REQ-022 SHALL, in HOLD or REPEAT with dir unchanged and counter expired, raise a step event, reload RPT_CYCLES, go to (or stay in) REPEAT; the steps are then spaced exactly DLY_CYCLES cycles (first repeat) and RPT_CYCLES cycles (later ones).
REQ-023 SHALL register position changes on the rising edge that acts on the step event; an offsetFlag bit set up before edge N changes the position at edge N+2.
REQ-024 SHALL use horizontal step HAL*CHM and vertical step VAL*CHM; the two axes are evaluated independently, so diagonal moves are allowed.
REQ-025 SHALL treat left+right together, or up+down together, as no move on that axis.
REQ-026 SHALL move left only if posHorStart >= HAL*CHM, right only if posHorEnd + HAL*CHM <= HDT, up only if posVerStart >= VAL*CHM, down only if posVerEnd + VAL*CHM <= VDT; a blocked axis holds its value (no clamp, no wrap).
REQ-027 SHALL perform bound arithmetic unsigned in PW+1 bits, so no intermediate overflow occurs.
REQ-028 SHALL update each End output on the same edge as its Start output; End never lags Start.
REQ-029 SHALL assert moved for exactly the cycle after an edge that changed any Start value; a fully blocked step event gives moved=0.

Reset
REQ-030 SHALL, on reset assertion and asynchronously, set posHorStart=(HDT-HAL*CHM)/2 (316), posHorEnd=324, posVerStart=(VDT-VAL*CHM)/2 (192), posVerEnd=208, moved=0, FSM=IDLE, counter=0, synchroniser flops=0.
REQ-031 SHALL, with a button held through reset release, produce exactly one step at the 3rd edge after release, then follow normal repeat timing.

Verification (DLY_CYCLES=4, RPT_CYCLES=2, other defaults)
REQ-032 SHALL check: assert reset -> outputs 316/324/192/208, moved=0, with no clock edge needed.
REQ-033 SHALL check: right high for 1 cycle, then low -> posHorStart=324, posHorEnd=332, exactly one moved pulse, FSM back to IDLE.
REQ-034 SHALL check: left held -> steps at t0, t0+4, t0+6, t0+8, and so on; stops at posHorStart=4; further events give moved=0. Right held from home -> stops at posHorEnd=636, posHorStart=628.
REQ-035 SHALL check: up+down high -> no vertical change, moved=0. up+right high -> posVerStart=176 and posHorStart=324 on the same edge.
REQ-036 SHALL check: dir changes from left to down mid-REPEAT -> immediate down step, then next repeat 4 cycles later.
REQ-037 SHALL check: reset asserted mid-REPEAT -> home values at once, FSM=IDLE, no spurious moved pulse after release.
